// File: rtl/mem_ctrl_split.sv
// mem_ctrl_split: RV32 load/store unit between execute and the ssram bus.
// Decodes LB/LH/LW/LBU/LHU/SB/SH/SW, computes EA = op1 + op2 and drives one
// aligned bus transaction (PH0). A word-crossing access gets a second one
// (PH1). Load data is merged and extended. A stalled ack is aborted with a
// fault after TIMEOUT cycles.
// Build option: define MISALIGN_SPLIT_EN to accept any alignment and split
// crossing accesses. Without it, misaligned requests fault with no bus cycle.
// Ports: clk, rst (async, active-high); instr/op1/op2/op3/enable request;
// busy/result/result_valid/fault completion; address, read_enable/read_data/
// read_ack, write_enable/write_byte_enable/write_data/write_ack bus.
module mem_ctrl_split #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [31:0]       op1,
  input  logic [31:0]       op2,
  input  logic [31:0]       op3,
  input  logic              enable,
  output logic              busy,
  output logic [31:0]       result,
  output logic              result_valid,
  output logic              fault,
  output logic [ADDR_W-1:0] address,
  output logic              read_enable,
  input  logic [31:0]       read_data,
  input  logic              read_ack,
  output logic              write_enable,
  output logic [3:0]        write_byte_enable,
  output logic [31:0]       write_data,
  input  logic              write_ack
);
  localparam int unsigned CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE = 2'd0, PH0 = 2'd1, PH1 = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic               is_load_q, is_load_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         o_q, o_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               fault_q, fault_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic               read_enable_q, read_enable_d;
  logic               write_enable_q, write_enable_d;
  logic [3:0]         wbe_q, wbe_d;
  logic [31:0]        wdata_q, wdata_d;
`ifdef MISALIGN_SPLIT_EN
  logic               cross_q, cross_d;
  logic [3:0]         ph1_be_q, ph1_be_d;
  logic [31:0]        ph1_wd_q, ph1_wd_d;
  logic [31:0]        lo_q, lo_d;
  logic [3:0]         be_hi;
`else
  logic               aligned;
`endif

  logic [31:0] ea;
  logic [2:0]  f3_in;
  logic        dec_load, dec_store, legal;
  logic [3:0]  mask;
  logic [4:0]  sh;
  logic        ack, tmo, finish, abort;
  logic [63:0] raw;
  logic        unused_instr;

  assign unused_instr = ^{instr[31:15], instr[11:7]};

  // Shift the (possibly two-word) raw data down to the access and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [1:0] o,
                                           input logic [63:0] r);
    logic [31:0] v;
    v = 32'(r >> {o, 3'b000});
    case (f[1:0])
      2'b00:   load_ext = f[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   load_ext = f[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: load_ext = v;
    endcase
  endfunction

  // Request decode and legality.
  always_comb begin
    ea        = op1 + op2;
    f3_in     = instr[14:12];
    dec_load  = (instr[6:0] == OPC_LOAD) &&
                (f3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    dec_store = (instr[6:0] == OPC_STORE) && (f3_in inside {3'b000, 3'b001, 3'b010});
    case (f3_in[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    sh = {ea[1:0], 3'b000};
`ifdef MISALIGN_SPLIT_EN
    be_hi = 4'(({4'b0000, mask} << ea[1:0]) >> 4);
    legal = dec_load | dec_store;
`else
    aligned = (f3_in[1:0] == 2'b00) || (f3_in[1:0] == 2'b01 && !ea[0]) || (ea[1:0] == 2'b00);
    legal   = (dec_load | dec_store) && aligned;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    is_load_d      = is_load_q;
    f3_d           = f3_q;
    o_d            = o_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    result_d       = '0;
    result_valid_d = 1'b0;
    fault_d        = 1'b0;
    address_d      = address_q;
    read_enable_d  = read_enable_q;
    write_enable_d = write_enable_q;
    wbe_d          = wbe_q;
    wdata_d        = wdata_q;
`ifdef MISALIGN_SPLIT_EN
    cross_d        = cross_q;
    ph1_be_d       = ph1_be_q;
    ph1_wd_d       = ph1_wd_q;
    lo_d           = lo_q;
`endif
    ack    = is_load_q ? read_ack : write_ack;
    tmo    = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    finish = 1'b0;
    abort  = 1'b0;
    raw    = '0;

    case (state_q)
      // DONE accepts a new request so back-to-back issue costs no bubble.
      IDLE, DONE: begin
        state_d = IDLE;
        if (enable) begin
          is_load_d = dec_load;
          f3_d      = f3_in;
          o_d       = ea[1:0];
          cnt_d     = '0;
          if (!legal) begin
            state_d        = DONE;
            result_valid_d = 1'b1;
            fault_d        = 1'b1;
          end else begin
            state_d        = PH0;
            busy_d         = 1'b1;
            address_d      = {ea[ADDR_W-1:2], 2'b00};
            read_enable_d  = dec_load;
            write_enable_d = dec_store;
            wbe_d          = dec_store ? (mask << ea[1:0]) : 4'b0000;
            wdata_d        = dec_store ? (op3 << sh) : 32'd0;
`ifdef MISALIGN_SPLIT_EN
            cross_d  = |be_hi;
            ph1_be_d = dec_store ? be_hi : 4'b0000;
            ph1_wd_d = dec_store ? 32'(({32'd0, op3} << sh) >> 32) : 32'd0;
`endif
          end
        end
      end
      PH0: begin
        if (ack) begin
`ifdef MISALIGN_SPLIT_EN
          lo_d = read_data;
          if (cross_q) begin
            state_d   = PH1;
            address_d = address_q + ADDR_W'(4);
            wbe_d     = ph1_be_q;
            wdata_d   = ph1_wd_q;
            cnt_d     = '0;
          end else begin
            finish = 1'b1;
            raw    = {32'd0, read_data};
          end
`else
          finish = 1'b1;
          raw    = {32'd0, read_data};
`endif
        end else if (tmo) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef MISALIGN_SPLIT_EN
      PH1: begin
        if (ack) begin
          finish = 1'b1;
          raw    = {read_data, lo_q};
        end else if (tmo) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Completion (normal or timeout): drop strobes and pulse result_valid.
    if (finish || abort) begin
      state_d        = DONE;
      busy_d         = 1'b0;
      read_enable_d  = 1'b0;
      write_enable_d = 1'b0;
      wbe_d          = 4'b0000;
      wdata_d        = 32'd0;
      result_valid_d = 1'b1;
      fault_d        = abort;
      result_d       = (finish && is_load_q) ? load_ext(f3_q, o_q, raw) : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      is_load_q      <= 1'b0;
      f3_q           <= '0;
      o_q            <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      address_q      <= '0;
      read_enable_q  <= 1'b0;
      write_enable_q <= 1'b0;
      wbe_q          <= '0;
      wdata_q        <= '0;
`ifdef MISALIGN_SPLIT_EN
      cross_q        <= 1'b0;
      ph1_be_q       <= '0;
      ph1_wd_q       <= '0;
      lo_q           <= '0;
`endif
    end else begin
      state_q        <= state_d;
      is_load_q      <= is_load_d;
      f3_q           <= f3_d;
      o_q            <= o_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      fault_q        <= fault_d;
      address_q      <= address_d;
      read_enable_q  <= read_enable_d;
      write_enable_q <= write_enable_d;
      wbe_q          <= wbe_d;
      wdata_q        <= wdata_d;
`ifdef MISALIGN_SPLIT_EN
      cross_q        <= cross_d;
      ph1_be_q       <= ph1_be_d;
      ph1_wd_q       <= ph1_wd_d;
      lo_q           <= lo_d;
`endif
    end
  end

  assign busy              = busy_q;
  assign result            = result_q;
  assign result_valid      = result_valid_q;
  assign fault             = fault_q;
  assign address           = address_q;
  assign read_enable       = read_enable_q;
  assign write_enable      = write_enable_q;
  assign write_byte_enable = wbe_q;
  assign write_data        = wdata_q;
endmodule

// File: tb/tb_mem_ctrl_split.sv
// Bench for mem_ctrl_split: byte-array bus memory, a transaction-level model
// producing per-cycle expected outputs, and one compare process at negedge.
`timescale 1ns/1ps
module tb_mem_ctrl_split;
  localparam int unsigned TMO = 4;
  localparam logic [31:0] LB = 32'h00000003, LH = 32'h00001003, LW = 32'h00002003;
  localparam logic [31:0] LBU = 32'h00004003, LHU = 32'h00005003;
  localparam logic [31:0] SB = 32'h00000023, SH = 32'h00001023, SW = 32'h00002023;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] instr, op1, op2, op3, result, read_data, write_data, address;
  logic enable, busy, result_valid, fault, read_enable, read_ack, write_enable, write_ack;
  logic [3:0] write_byte_enable;

  always #5 clk = ~clk;

  mem_ctrl_split #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .op1(op1), .op2(op2), .op3(op3),
    .enable(enable), .busy(busy), .result(result), .result_valid(result_valid),
    .fault(fault), .address(address), .read_enable(read_enable),
    .read_data(read_data), .read_ack(read_ack), .write_enable(write_enable),
    .write_byte_enable(write_byte_enable), .write_data(write_data),
    .write_ack(write_ack)
  );

  // Bus-side memory (written by the DUT) and model memory (written by the model).
  logic [7:0] bus_mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic mem_init;

  assign read_data = {bus_mem[address[9:0] + 10'd3], bus_mem[address[9:0] + 10'd2],
                      bus_mem[address[9:0] + 10'd1], bus_mem[address[9:0]]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) bus_mem[i] = 8'(i) ^ 8'h5A;
    end else if (!rst && write_enable && write_ack) begin
      for (int k = 0; k < 4; k++)
        if (write_byte_enable[k]) bus_mem[address[9:0] + 10'(k)] = write_data[8*k +: 8];
    end
  end

  typedef struct {
    logic        busy, re, we, rv, fault;
    logic [31:0] addr, wd, result;
    logic [3:0]  be;
  } rec_t;

  rec_t exp_q[$];
  logic [31:0] addr_log[$];
  logic [3:0]  be_log[$];
  logic [31:0] last_result, model_result;
  logic        last_fault;
  bit          manual;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: expected output per cycle after enable is sampled.
  task automatic model_txn(input logic [31:0] ins, a, b, d, input bit ack_ok);
    logic [31:0] ea, base, wd0, wd1, val;
    logic [2:0]  f3;
    logic [3:0]  be0, be1;
    bit          ld, st, ok;
    int          size, o, n0;
    rec_t        r;
    f3   = ins[14:12];
    ld   = (ins[6:0] == 7'h03) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    st   = (ins[6:0] == 7'h23) && (f3 <= 2);
    size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    ea   = a + b;
    o    = int'(ea[1:0]);
    base = ea & ~32'd3;
    ok   = ld || st;
`ifndef MISALIGN_SPLIT_EN
    if ((o % size) != 0) ok = 0;
`endif
    r = '{default: 0};
    if (!ok) begin
      r.rv = 1; r.fault = 1;
      exp_q.push_back(r);
      model_result = 0;
      return;
    end
    n0  = (4 - o < size) ? 4 - o : size;
    be0 = 0; be1 = 0;
    for (int k = 0; k < n0; k++) be0[o + k] = 1'b1;
    for (int k = n0; k < size; k++) be1[k - n0] = 1'b1;
    wd0 = d << (8 * o);
    wd1 = (size > n0) ? (d >> (8 * (4 - o))) : 32'd0;
    val = 0;
    for (int k = 0; k < size; k++) val[8*k +: 8] = ref_mem[10'(ea + 32'(k))];
    if (ld && !f3[2] && size < 4 && val[8*size-1]) val = val | (~32'd0 << (8 * size));
    if (st && ack_ok)
      for (int k = 0; k < size; k++) ref_mem[10'(ea + 32'(k))] = d[8*k +: 8];
    r.busy = 1; r.re = ld; r.we = st; r.addr = base; r.be = be0; r.wd = wd0;
    if (ack_ok) begin
      exp_q.push_back(r);
      if (size > n0) begin
        r.addr = base + 32'd4; r.be = be1; r.wd = wd1;
        exp_q.push_back(r);
      end
      r = '{default: 0}; r.rv = 1; r.result = ld ? val : 32'd0;
      model_result = r.result;
    end else begin
      repeat (TMO) exp_q.push_back(r);
      r = '{default: 0}; r.rv = 1; r.fault = 1;
      model_result = 0;
    end
    exp_q.push_back(r);
  endtask

  // Compare process: one expected record per cycle, idle checks otherwise.
  always @(negedge clk) begin : cmp
    rec_t r;
    if (!rst && !manual) begin
      if (read_enable || write_enable) addr_log.push_back(address);
      if (write_enable) be_log.push_back(write_byte_enable);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("busy", 32'(busy), 32'(r.busy));
        check("read_enable", 32'(read_enable), 32'(r.re));
        check("write_enable", 32'(write_enable), 32'(r.we));
        check("result_valid", 32'(result_valid), 32'(r.rv));
        if (r.re || r.we) check("address", address, r.addr);
        if (r.we) begin
          check("byte_enable", 32'(write_byte_enable), 32'(r.be));
          check("write_data", write_data, r.wd);
        end
        if (r.rv) begin
          check("fault", 32'(fault), 32'(r.fault));
          check("result", result, r.result);
        end
      end else begin
        check("idle", 32'({busy, read_enable, write_enable, result_valid}), 32'd0);
      end
      if (result_valid) begin
        last_result = result;
        last_fault  = fault;
      end
    end
  end

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (exp_q.size() != 0 && n < 64);
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run(input logic [31:0] ins, a, b, d, input bit ack_ok);
    read_ack = ack_ok; write_ack = ack_ok;
    model_txn(ins, a, b, d, ack_ok);
    instr = ins; op1 = a; op2 = b; op3 = d; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    drain();
  endtask

  initial begin
    mem_init = 1'b1; manual = 1'b1; rst = 1'b1; enable = 1'b0;
    instr = 0; op1 = 0; op2 = 0; op3 = 0; read_ack = 1'b1; write_ack = 1'b1;
    last_result = 0; last_fault = 0; model_result = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    @(posedge clk); #1 mem_init = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_result", result, 0);
    check("rst_rv", 32'(result_valid), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_address", address, 0);
    check("rst_re", 32'(read_enable), 0);
    check("rst_we", 32'(write_enable), 0);
    check("rst_be", 32'(write_byte_enable), 0);
    check("rst_wd", write_data, 0);
    #1 rst = 1'b0; manual = 1'b0;
    @(negedge clk); #1;

    // Illegal opcodes: immediate fault, no strobe.
    addr_log.delete();
    run(32'h00000033, 32'h40, 0, 0, 1);
    check("illegal_fault", 32'(last_fault), 1);
    run(32'h00003003, 32'h40, 0, 0, 1);
    run(32'h00004023, 32'h40, 0, 0, 1);
    check("illegal_no_strobe", addr_log.size(), 0);

    // LH at the top of the address space wraps into word 0.
    addr_log.delete();
    run(LH, 32'hFFFF_FFFF, 0, 0, 1);
`ifdef MISALIGN_SPLIT_EN
    check("wrap_model", model_result, 32'h0000_5AA5);
    check("wrap_result", last_result, 32'h0000_5AA5);
    check("wrap_nstrobe", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check("wrap_ph0_addr", addr_log[0], 32'hFFFF_FFFC);
      check("wrap_ph1_addr", addr_log[1], 32'h0000_0000);
    end
`else
    check("wrap_fault", 32'(last_fault), 1);
    check("wrap_no_strobe", addr_log.size(), 0);
`endif

    // SW/LW sweep, back-to-back with acks tied high.
    for (int i = 0; i < 16; i++) begin
      run(SW, 0, 32'(4 * i), 32'(i), 1);
      run(LW | 32'hFFF0_8F80, 0, 32'(4 * i), 0, 1);
      check("sweep_result", last_result, 32'(i));
    end

    // Byte and halfword extension.
    run(SB, 32'h40, 0, 32'h1234_5680, 1);
    run(LB, 32'h40, 0, 0, 1);
    check("lb_model", model_result, 32'hFFFF_FF80);
    check("lb_result", last_result, 32'hFFFF_FF80);
    run(LBU, 32'h3F, 1, 0, 1);
    check("lbu_result", last_result, 32'h0000_0080);
    run(SH, 32'h40, 2, 32'h0000_F00D, 1);
    run(LH, 32'h42, 0, 0, 1);
    check("lh_result", last_result, 32'hFFFF_F00D);
    run(LHU, 32'h42, 0, 0, 1);
    check("lhu_result", last_result, 32'h0000_F00D);

    // Word-crossing store and load.
    addr_log.delete(); be_log.delete();
    run(SW, 32'h100, 2, 32'hAABB_CCDD, 1);
`ifdef MISALIGN_SPLIT_EN
    check("split_nstrobe", addr_log.size(), 2);
    if (be_log.size() == 2) begin
      check("split_ph0_be", 32'(be_log[0]), 32'hC);
      check("split_ph1_be", 32'(be_log[1]), 32'h3);
      check("split_ph0_addr", addr_log[0], 32'h100);
      check("split_ph1_addr", addr_log[1], 32'h104);
    end
    run(LW, 32'h102, 0, 0, 1);
    check("split_lw", last_result, 32'hAABB_CCDD);
`else
    check("split_fault", 32'(last_fault), 1);
    check("split_no_strobe", addr_log.size(), 0);
    run(LW, 32'h102, 0, 0, 1);
`endif
    run(LH, 32'h101, 0, 0, 1);
    run(SH, 32'h103, 0, 32'h0000_7E7F, 1);
    run(LHU, 32'h103, 0, 0, 1);

    // Ack timeout, then a normal access.
    addr_log.delete();
    run(LW, 32'h40, 0, 0, 0);
    check("tmo_cycles", addr_log.size(), TMO);
    check("tmo_fault", 32'(last_fault), 1);
    check("tmo_result", last_result, 0);
    run(LW, 32'h40, 0, 0, 1);
    check("tmo_recover", last_result, 32'hF00D_1B80);

    // Reset while PH0 waits: strobes and busy drop asynchronously.
    manual = 1'b1; read_ack = 1'b0;
    instr = LW; op1 = 32'h40; op2 = 0; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_re", 32'(read_enable), 1);
    @(negedge clk); #1 rst = 1'b1; #1;
    check("rst_mid_re", 32'(read_enable), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_we", 32'(write_enable), 0);
    @(negedge clk); #1 rst = 1'b0; read_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_rv", 32'(result_valid), 0);
      check("rst_mid_idle_busy", 32'(busy), 0);
    end
    #1 manual = 1'b0;
    run(LBU, 32'h40, 0, 0, 1);
    check("post_rst_lbu", last_result, 32'h0000_0080);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end
endmodule
